// File: rtl/uart_tx_fifo_if.sv
// Byte write channel into the buffered UART transmitter (valid/ready handshake).
interface uart_tx_fifo_if;
  logic [7:0] Tx_Data;
  logic       Tx_Valid;
  logic       Tx_Ready;

  modport master (output Tx_Data, output Tx_Valid, input  Tx_Ready);
  modport slave  (input  Tx_Data, input  Tx_Valid, output Tx_Ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [14:0]   BR_Clocks,
  uart_tx_fifo_if.slave tx,
  output logic          Tx_Serial,
  output logic          Tx_Busy,
  output logic [CW-1:0] Fifo_Count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t         state_q, state_d;
  logic [14:0]    timer_q, timer_d, br_q, br_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     idx_q, idx_d;
  logic           serial_q, serial_d, busy_q, busy_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           ready_q, ready_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic           wr_en, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  assign wr_en       = tx.Tx_Valid & ready_q;
  assign bit_end     = (timer_q == br_q - 15'd1);
  assign tx.Tx_Ready = ready_q;
  assign Tx_Serial   = serial_q;
  assign Tx_Busy     = busy_q;
  assign Fifo_Count  = count_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    br_d     = br_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: pop = (count_q != '0);
      START: begin
        timer_d = timer_q + 15'd1;
        if (bit_end) begin
          timer_d  = '0;
          state_d  = DATA;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        timer_d = timer_q + 15'd1;
        if (bit_end) begin
          timer_d = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = par_q;
`else
            state_d  = STOP;
            serial_d = 1'b1;
`endif
          end else begin
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        timer_d = timer_q + 15'd1;
        if (bit_end) begin
          timer_d  = '0;
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
`endif
      STOP: begin
        timer_d = timer_q + 15'd1;
        if (bit_end) begin
          timer_d = '0;
          if (count_q != '0) pop = 1'b1;
          else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame start: the divisor is captured here only, so mid-frame changes wait a frame.
    if (pop) begin
      state_d  = START;
      shift_d  = mem_q[rd_ptr_q];
      br_d     = (BR_Clocks == '0) ? 15'd1 : BR_Clocks;
      timer_d  = '0;
      serial_d = 1'b0;
      busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d    = ^mem_q[rd_ptr_q];
`endif
    end
  end

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    ready_d = (count_d != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= tx.Tx_Data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      br_q     <= 15'd1;
      shift_q  <= '0;
      idx_q    <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      br_q     <= br_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shape, backpressure, divisor relatch, async reset.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] br;
  logic        serial, busy;
  logic [2:0]  cnt;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  uart_tx_fifo_if txif ();

  uart_tx_fifo #(.FIFO_DEPTH(4), .CW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BR_Clocks  (br),
    .tx         (txif),
    .Tx_Serial  (serial),
    .Tx_Busy    (busy),
    .Fifo_Count (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit, then samples each bit at its centre.
  task automatic rx_frame(input int b, output logic [7:0] d, output logic stp,
                          output int t0, output logic ok);
    int n;
    logic p;
    ok = 1'b0; n = 0; d = '0; stp = 1'b0; t0 = 0;
    while (serial !== 1'b0 && n < 40*b + 100) begin
      @(negedge clk); n++;
    end
    if (serial !== 1'b0) return;
    t0 = cyc;
    repeat (b/2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (b) @(negedge clk);
      d[i] = serial;
    end
`ifdef UART_TX_PARITY_EN
    repeat (b) @(negedge clk);
    p = serial;
    chk("parity_bit", p, ^d);
`else
    p = 1'b0;
`endif
    repeat (b) @(negedge clk);
    stp = serial;
    ok  = 1'b1;
  endtask

  initial begin
    int k, g, t0, t1;
    logic [7:0] d;
    logic stp, ok, saw_full, bad;
`ifdef UART_TX_PARITY_EN
    logic [0:10] seq;
    seq = 11'b01010010101;
`else
    logic [0:9] seq;
    seq = 10'b0101001011;
`endif
    saw_full = 1'b0;
    txif.Tx_Valid = 1'b0;
    txif.Tx_Data  = 8'h00;
    br = 15'd868;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_serial", serial, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", txif.Tx_Ready, 1'b1);
    chk("rst_count", cnt, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0xA5 at divisor 868
    txif.Tx_Data = 8'hA5; txif.Tx_Valid = 1'b1;
    @(negedge clk);
    txif.Tx_Valid = 1'b0;
    chk("wr_count1", cnt, 3'd1);
    chk("wr_serial_idle", serial, 1'b1);
    @(negedge clk);
    chk("start_count0", cnt, 3'd0);
    chk("start_serial0", serial, 1'b0);
    chk("start_busy1", busy, 1'b1);
    k = 0;
    while (busy === 1'b1 && k < 20000) begin
      if (k % 868 == 434) chk("a5_bit", serial, seq[k/868]);
      k++;
      @(negedge clk);
    end
    chk("a5_busy_len", k, NB*868);
    chk("a5_idle_serial", serial, 1'b1);
    chk("a5_idle_count", cnt, 3'd0);

    // Backpressure: six bytes streamed with Tx_Valid held
    br = 15'd4;
    fork
      begin
        int i, gw;
        logic r;
        i = 0; gw = 0;
        while (i < 6 && gw < 2000) begin
          txif.Tx_Data  = 8'(8'h10 + i);
          txif.Tx_Valid = 1'b1;
          r = txif.Tx_Ready;
          if (cnt == 3'd4 && r == 1'b0 && busy == 1'b1) saw_full = 1'b1;
          @(negedge clk);
          if (r) i++;
          gw++;
        end
        txif.Tx_Valid = 1'b0;
        chk("bp_all_written", i, 6);
      end
      begin
        int tp, ts;
        logic [7:0] dd;
        logic sp, okk;
        tp = 0;
        for (int j = 0; j < 6; j++) begin
          rx_frame(4, dd, sp, ts, okk);
          chk("bp_frame_seen", okk, 1'b1);
          chk("bp_data", dd, 8'(8'h10 + j));
          chk("bp_stop", sp, 1'b1);
          if (j > 0) chk("bp_gap", ts - tp, NB*4);
          tp = ts;
        end
      end
    join
    chk("bp_full_seen", saw_full, 1'b1);
    g = 0;
    while (busy !== 1'b0 && g < 200) begin @(negedge clk); g++; end
    chk("bp_wait_ok", (g < 200), 1'b1);
    chk("bp_drained_busy", busy, 1'b0);
    chk("bp_drained_count", cnt, 3'd0);
    chk("bp_ready_back", txif.Tx_Ready, 1'b1);

    // Divisor change mid-frame takes effect on the next frame
    br = 15'd8;
    txif.Tx_Data = 8'h5A; txif.Tx_Valid = 1'b1;
    @(negedge clk);
    txif.Tx_Data = 8'hC3;
    @(negedge clk);
    txif.Tx_Valid = 1'b0;
    t0 = 0; t1 = 0;
    fork
      begin repeat (30) @(negedge clk); br = 15'd4; end
      begin
        rx_frame(8, d, stp, t0, ok);
        chk("div_f1_seen", ok, 1'b1);
        chk("div_f1_data", d, 8'h5A);
        rx_frame(4, d, stp, t1, ok);
        chk("div_f2_seen", ok, 1'b1);
        chk("div_f2_data", d, 8'hC3);
        chk("div_f1_len", t1 - t0, NB*8);
      end
    join
    g = 0;
    while (busy !== 1'b0 && g < 200) begin @(negedge clk); g++; end
    chk("div_wait_ok", (g < 200), 1'b1);
    chk("div_f2_len", cyc - t1, NB*4);

    // Async reset during data bit 3 of 0x3C with two bytes queued
    br = 15'd8;
    txif.Tx_Data = 8'h3C; txif.Tx_Valid = 1'b1;
    @(negedge clk);
    txif.Tx_Data = 8'h11;
    @(negedge clk);
    chk("rm_start", serial, 1'b0);
    txif.Tx_Data = 8'h22;
    @(negedge clk);
    txif.Tx_Valid = 1'b0;
    repeat (34) @(negedge clk);
    chk("rm_pre_count", cnt, 3'd2);
    chk("rm_pre_bit3", serial, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rm_serial", serial, 1'b1);
    chk("rm_count", cnt, 3'd0);
    chk("rm_ready", txif.Tx_Ready, 1'b1);
    chk("rm_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (serial !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("rm_no_resume", bad, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: the serial source that drives the `Rx_Serial` input of `UART_Rx`. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each byte as 8N1, LSB first. Bit time is set by the same runtime `BR_Clocks` divisor the receiver uses, so a TX→RX loopback needs only a shared divisor value.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: byte entries; power of two, ≥2.
- `CW`, default 3: width of `Fifo_Count`, equal to log2(`FIFO_DEPTH`)+1.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous and active-low.
- `BR_Clocks` in 15: clocks per serial bit; sampled at each frame start.
- `Tx_Data` in 8: byte to transmit.
- `Tx_Valid` in 1: `Tx_Data` is valid this cycle.
- `Tx_Ready` out 1: FIFO can accept a byte; high iff not full.
- `Tx_Serial` out 1: serial line; idles high.
- `Tx_Busy` out 1: high while a frame is on the line (state ≠ IDLE).
- `Fifo_Count` out CW: bytes held in the FIFO, excluding the byte in flight.

## Operation
- Write: a byte is accepted on any rising edge with `Tx_Valid & Tx_Ready`. There is no other effect; `Tx_Data` is ignored otherwise.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the macro).
- IDLE → START when the FIFO is non-empty. On that edge:
  - pop the head byte into the shift register;
  - latch `BR_Clocks` into `br_q` (a value of 0 is treated as 1);
  - clear the bit-timer;
  - drive `Tx_Serial` low.
- Bit-timer: counts 0..`br_q`-1. Each state holds its bit for exactly `br_q` clocks.
- START → DATA: output shift[0]. Shift right after each bit.
- DATA → STOP after 8 bits. A 3-bit index wraps 7→0 on exit.
- STOP: `Tx_Serial`=1 for `br_q` clocks. At the end of STOP:
  - FIFO non-empty → go directly to START (pop, relatch `BR_Clocks`); no idle gap beyond the stop bit;
  - FIFO empty → go to IDLE.
- A change on `BR_Clocks` mid-frame has no effect until the next frame start.
- FIFO uses circular read/write pointers with an explicit count; pointers wrap at `FIFO_DEPTH`.
- Same-edge write and pop:
  - count unchanged;
  - both accepted when not full;
  - when full, `Tx_Ready` is already low, so the write is refused even though a pop occurs that edge.
- Reset (async, any time, including mid-frame):
  - FIFO emptied, state IDLE;
  - `Tx_Serial`=1, `Tx_Busy`=0, `Tx_Ready`=1, `Fifo_Count`=0;
  - a partial frame is abandoned and not resumed.

## Timing
- All outputs are registered.
- Write into an empty FIFO while IDLE on edge N:
  - `Fifo_Count`=1 after N;
  - START entered on N+1; `Tx_Serial` falls after edge N+1; `Fifo_Count` returns to 0 after N+1.
- Frame length: 10·`br_q` clocks (11·`br_q` with parity).
- Back-to-back frames: the next start bit immediately follows the last stop-bit clock.
- `Tx_Busy` rises with the start bit. It falls on the edge that enters IDLE.
- `Tx_Ready` falls on the edge where count reaches `FIFO_DEPTH`. It rises on the edge of the next pop.
- With `BR_Clocks`=868 and a 2 ns clock: bit = 1736 ns; frame = 17360 ns.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP;
  - it drives even parity (XOR of the 8 data bits) for `br_q` clocks;
  - frame is 11 bits.
- Undefined: no PARITY state; 8N1, 10-bit frame. The ports are identical in both builds.

## Test plan
- Single byte 0xA5, `BR_Clocks`=868: sample `Tx_Serial` at bit centres (every 1736 ns) → sequence 0,1,0,1,0,0,1,0,1,1. `Tx_Busy` high for exactly 8680 clocks. Idle high afterwards.
- Loopback to `UART_Rx` (`BR_Clocks`=868): write 0x00..0xFF while honouring `Tx_Ready` → every `Rx_Data` equals the byte sent; 0 mismatches.
- Backpressure: hold `Tx_Valid`=1 with bytes 0x10..0x15 → `Tx_Ready` low once `Fifo_Count`=4, with one byte in flight. Six frames are emitted in order with no gaps between stop and start bits.
- Divisor change: set `BR_Clocks` from 868 to 434 mid-frame → the current frame keeps 868-clock bits; the next frame uses 434.
- Reset mid-frame: assert `rst_n`=0 during bit 3 of 0x3C with 2 bytes queued → `Tx_Serial`=1, `Fifo_Count`=0, `Tx_Ready`=1 immediately. No further frames after release.
- Parity build: send 0x07 → 11-bit frame with parity bit = 1; send 0x03 → parity bit = 0.
